// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-requester burst arbiter for the single read/write port
//                of the shared accelerator word memory.
//                Port 0 is the SPI-side host loader. Port 1 is the systolic
//                array writeback/fetch path.
//                Whole bursts are granted with round-robin fairness. A
//                starvation cap forces release after MAX_BURST beats. Read
//                data from the memory (one-cycle latency) is steered back to
//                the port that issued the read.
//
//  Ports
//    clk, reset              : clock, asynchronous active-high reset
//    reqN / weN / addrN      : per-port beat request, write flag, address
//    wdataN / lastN          : per-port write data, final-beat marker
//    gntN                    : beat accepted this cycle (combinational)
//    rvalidN / rdataN        : per-port read return (rdata mirrors r_data)
//    w_addr / w_data / w_en  : memory write port
//    r_addr / r_data         : memory read port (data returns next cycle)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_SIZE = 11,
    parameter int WORD_SIZE = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic                 last0,
    output logic                 gnt0,
    output logic                 rvalid0,
    output logic [WORD_SIZE-1:0] rdata0,

    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata1,
    input  logic                 last1,
    output logic                 gnt1,
    output logic                 rvalid1,
    output logic [WORD_SIZE-1:0] rdata1,

    output logic [ADDR_SIZE-1:0] w_addr,
    output logic [WORD_SIZE-1:0] w_data,
    output logic                 w_en,
    output logic [ADDR_SIZE-1:0] r_addr,
    input  logic [WORD_SIZE-1:0] r_data
);

    // Beat counter is wide enough to hold MAX_BURST itself, so the
    // "next count reaches the cap" compare needs no special casing.
    localparam int                 CNT_W       = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]   c_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic               c_SINGLE    = (MAX_BURST == 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    logic [1:0]           r_state;
    logic                 r_rr_ptr;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 r_rd_pend;
    logic                 r_rd_tag;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_accept;
    logic                 w_sel;
    logic                 w_sel_we;
    logic                 w_sel_last;
    logic [ADDR_SIZE-1:0] w_sel_addr;
    logic [WORD_SIZE-1:0] w_sel_wdata;
    logic                 w_owner;
    logic                 w_owner_req;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_own_release;

    // ------------------------------------------------------------------
    // Grant decode. Reset gates the grants directly so that an
    // asynchronous reset mid-burst kills the accept (and hence the
    // memory strobes) in the same cycle, not at the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                c_OWN0: w_gnt0 = req0;
                c_OWN1: w_gnt1 = req1;
                default: begin
                    // Uncontested request wins; on contention rr_ptr decides.
                    w_gnt0 = req0 && (!req1 || !r_rr_ptr);
                    w_gnt1 = req1 && (!req0 ||  r_rr_ptr);
                end
            endcase
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign w_accept = w_gnt0 || w_gnt1;
    assign w_sel    = w_gnt1;

    assign w_sel_we    = w_sel ? we1    : we0;
    assign w_sel_last  = w_sel ? last1  : last0;
    assign w_sel_addr  = w_sel ? addr1  : addr0;
    assign w_sel_wdata = w_sel ? wdata1 : wdata0;

    // Owner of the current burst and whether it is still requesting.
    assign w_owner     = (r_state == c_OWN1);
    assign w_owner_req = w_owner ? req1 : req0;
    assign w_cnt_inc   = r_beat_cnt + c_CNT_ONE;

    // Leave an OWN state on a bubble, an explicit last beat, or when the
    // beat just accepted hits the starvation cap.
    assign w_own_release = !w_owner_req || w_sel_last || (w_cnt_inc == c_MAX_BURST);

    // ------------------------------------------------------------------
    // Memory port mux: everything is zero when no beat is accepted so
    // the memory sees clean, quiet inputs between beats.
    // ------------------------------------------------------------------
    always_comb begin
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        r_addr = '0;
        if (w_accept) begin
            if (w_sel_we) begin
                w_en   = 1'b1;
                w_addr = w_sel_addr;
                w_data = w_sel_wdata;
            end else begin
                r_addr = w_sel_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                c_OWN0, c_OWN1: begin
                    if (w_own_release) begin
                        r_state    <= c_IDLE;
                        r_rr_ptr   <= ~w_owner;
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    // Also recovers the unused encoding back to IDLE.
                    r_state <= c_IDLE;
                    if (w_accept) begin
                        if (w_sel_last || c_SINGLE) begin
                            r_rr_ptr   <= ~w_sel;
                            r_beat_cnt <= '0;
                        end else begin
                            r_state    <= w_sel ? c_OWN1 : c_OWN0;
                            r_beat_cnt <= c_CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read return. The tag captured at accept time, not the current
    // owner, routes the data, so a read on the final beat before a grant
    // switch still returns to its issuer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            r_rd_pend <= w_accept && !w_sel_we;
            if (w_accept && !w_sel_we) begin
                r_rd_tag <= w_sel;
            end
        end
    end

    assign rvalid0 = r_rd_pend && !r_rd_tag;
    assign rvalid1 = r_rd_pend &&  r_rd_tag;
    assign rdata0  = r_data;
    assign rdata1  = r_data;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single read/write port of the accelerator's shared word memory. It sits between the memory and two masters: port 0 is the SPI-side host loader (vector/matrix upload, result readout) and port 1 is the controller's systolic-array writeback/fetch path. It grants whole bursts with round-robin fairness and a starvation cap. It routes the memory's one-cycle-latency read data back to whichever port issued the read.

## Interface
Parameters:
- ADDR_SIZE, 11, memory address width
- WORD_SIZE, 16, memory word width
- MAX_BURST, 16, maximum accepted beats per grant before forced release (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  port requests a beat this cycle
- we0 / we1  in  1  beat is a write (1) or read (0)
- addr0 / addr1  in  ADDR_SIZE  beat address
- wdata0 / wdata1  in  WORD_SIZE  write data
- last0 / last1  in  1  beat is the final one of the burst
- gnt0 / gnt1  out  1  beat accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for that port (registered)
- rdata0 / rdata1  out  WORD_SIZE  read data; equals r_data, qualified by rvalid
- w_addr  out  ADDR_SIZE  memory write address
- w_data  out  WORD_SIZE  memory write data
- w_en  out  1  memory write enable
- r_addr  out  ADDR_SIZE  memory read address (memory returns r_data next cycle)
- r_data  in  WORD_SIZE  memory read data

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: state, rr_ptr (port favoured in IDLE), beat_cnt (log2(MAX_BURST)+1 bits), rd_pend (1 bit), rd_tag (1 bit).
- IDLE: if only one req is high, grant it. If both are high, grant the port rr_ptr favours. If neither is high, grant nothing.
  - Granted beat with last=1, or with MAX_BURST=1: stay IDLE and set rr_ptr to the other port.
  - Otherwise go to OWNx with beat_cnt=1.
- OWNx: only port x can be granted; gntx = reqx. The other port's gnt is 0.
  - Beat accepted with last=1: go to IDLE, rr_ptr ← other port, beat_cnt ← 0.
  - Beat accepted with beat_cnt+1 == MAX_BURST: forced release. Same transition as last=1. The requester must re-request to continue.
  - reqx low for a cycle: release to IDLE, rr_ptr ← other port. No lock is held across bubbles.
  - Otherwise beat_cnt increments.
- Memory mux (combinational from the granted port):
  - Accepted write beat: w_en=1, w_addr=addr, w_data=wdata.
  - Accepted read beat: r_addr=addr, w_en=0.
  - No beat accepted: w_en=0, w_addr=0, w_data=0, r_addr=0.
- Read return: an accepted read sets rd_pend=1 and rd_tag=port for the next cycle. In that cycle rvalid[rd_tag]=1, and both rdata outputs show r_data.
  - Routing follows the tag, not the current owner, so a read on the last beat before a grant switch returns to the correct port.
- Write-then-read at the same address in consecutive beats returns the new data. Write-during-read behaviour is inherited from the memory.

## Timing
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, rd_pend=0, rd_tag=0.
  - All outputs are 0 while reset is high and with no req.
- Reset asserted mid-burst: FSM returns to IDLE immediately and any in-flight rvalid is squashed. The read is lost and the requester must reissue it.
- Grant latency is 0 cycles: gnt is combinational from req and state, and a beat is accepted in the cycle req&&gnt.
- Write lands at the clock edge ending the accept cycle. Read data arrives as rvalid one cycle after accept.
- Throughput is one beat per cycle. A burst that ends in cycle N lets the other port be granted in cycle N+1, with no dead cycle.
- beat_cnt never exceeds MAX_BURST-1 in any OWN state.
- A requester must hold addr/we/wdata/last stable while req is high and gnt is low.

## Test plan
- Single write then read: port0 writes 0xBEEF to addr 0x010 (last=1), then reads 0x010 → gnt0 in both cycles, w_en=1 once, rvalid0 one cycle after the read with rdata0=0xBEEF, rvalid1 never asserted.
- Simultaneous requests after reset: req0=req1=1 with single-beat bursts → grants alternate 0,1,0,1 per cycle; rr_ptr toggles each cycle.
- Burst lock: port1 issues a 4-beat burst (last on beat 4) while port0 requests continuously → gnt1 for 4 consecutive cycles, gnt0=0 throughout, gnt0=1 in cycle 5.
- Starvation cap with MAX_BURST=4: port0 streams 10 beats without last while port1 is waiting → port0 gets 4 beats, port1 gets its burst, then port0 resumes.
- Read across grant switch: port0 read of addr 0x005 (0x1234) with last=1, then port1 write in the next cycle → rvalid0=1 with rdata0=0x1234 in port1's grant cycle, rvalid1=0.
- Async reset mid-burst: assert reset during beat 2 of a port1 read burst → gnt/rvalid/w_en drop to 0 immediately; after release, the first req0 is granted from IDLE.
